// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM search engine: default geometry and flush FSM encoding.
package tcam_pkg;

  localparam int unsigned TCAM_WIDTH = 16;
  localparam int unsigned TCAM_DEPTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tcam_state_e;

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational match-vector reduction: lowest set index, any-hit and popcount.
module tcam_prio_enc
  import tcam_pkg::*;
#(
  parameter  int unsigned DEPTH = TCAM_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] match,
  output logic [AW-1:0]    idx_c,
  output logic             any_c,
  output logic [CW-1:0]    count_c
);

  // Scan from the top so the lowest matching index wins; count all matches.
  always_comb begin
    idx_c   = '0;
    any_c   = 1'b0;
    count_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx_c = AW'(i);
        any_c = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      count_c = count_c + CW'(match[i]);
    end
  end

endmodule

// File: rtl/tcam_search_engine.sv
// Ternary CAM with per-entry masks, sequenced flush and a two-stage search pipeline.
module tcam_search_engine
  import tcam_pkg::*;
#(
  parameter  int unsigned WIDTH = TCAM_WIDTH,
  parameter  int unsigned DEPTH = TCAM_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             inv_en,
  input  logic             flush,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             srch_valid,
  input  logic [WIDTH-1:0] srch_key,
  output logic             busy,
  output logic             rsp_valid,
  output logic             hit,
  output logic             multi_hit,
  output logic [AW-1:0]    hit_idx,
  output logic [WIDTH-1:0] hit_data,
  output logic [CW-1:0]    hit_count
);

  tcam_state_e      state;
  tcam_state_e      state_nxt;
  logic [AW-1:0]    ptr;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] mask_mem [DEPTH];

  logic             idle_c;
  logic             flush_go_c;
  logic             clr_c;
  logic             addr_ok_c;
  logic             wr_acc_c;
  logic             inv_acc_c;
  logic             srch_acc_c;
  logic [DEPTH-1:0] match_c;

  logic             s1_valid;
  logic [DEPTH-1:0] s1_match;
  logic [AW-1:0]    enc_idx_c;
  logic             enc_any_c;
  logic [CW-1:0]    enc_cnt_c;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  if ((1 << AW) == DEPTH) begin : g_addr_full
    assign addr_ok_c = 1'b1;
  end else begin : g_addr_part
    assign addr_ok_c = (32'(addr) < DEPTH);
  end

  // Flush FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Flush FSM next state: leave FLUSH after the last entry is cleared.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (flush) state_nxt = ST_FLUSH;
      ST_FLUSH: if (ptr == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Flush FSM outputs: accept a new flush when idle, clear one entry per cycle when flushing.
  always_comb begin
    idle_c     = 1'b0;
    flush_go_c = 1'b0;
    clr_c      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        idle_c     = 1'b1;
        flush_go_c = flush;
      end
      ST_FLUSH: clr_c = 1'b1;
      default: ;
    endcase
  end

  // A starting flush wins over updates and drops a same-cycle search.
  assign wr_acc_c   = idle_c && !flush && wr_en && addr_ok_c;
  assign inv_acc_c  = idle_c && !flush && !wr_en && inv_en && addr_ok_c;
  assign srch_acc_c = idle_c && !flush && srch_valid;

  // Busy flag mirrors the FSM being in FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_nxt == ST_FLUSH);
  end

  // Flush pointer walks every entry once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ptr <= '0;
    else if (flush_go_c) ptr <= '0;
    else if (clr_c)      ptr <= ptr + AW'(1);
  end

  // Valid bits: flush clear, then write, then invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            valid       <= '0;
    else if (clr_c)     valid[ptr]  <= 1'b0;
    else if (wr_acc_c)  valid[addr] <= 1'b1;
    else if (inv_acc_c) valid[addr] <= 1'b0;
  end

  // Pattern and mask storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      data_mem[addr] <= wr_data;
      mask_mem[addr] <= wr_mask;
    end
  end

  // Ternary compare of the key against the pre-edge table.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_c[i] = valid[i] && (((srch_key ^ data_mem[i]) & ~mask_mem[i]) == '0);
    end
  end

  tcam_prio_enc #(
    .DEPTH (DEPTH)
  ) u_prio_enc (
    .match   (s1_match),
    .idx_c   (enc_idx_c),
    .any_c   (enc_any_c),
    .count_c (enc_cnt_c)
  );

  // Stage 1 captures the match vector; stage 2 registers the encoded response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_match  <= '0;
      rsp_valid <= 1'b0;
      hit       <= 1'b0;
      multi_hit <= 1'b0;
      hit_idx   <= '0;
      hit_data  <= '0;
      hit_count <= '0;
    end else begin
      s1_valid  <= srch_acc_c;
      if (srch_acc_c) s1_match <= match_c;
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        hit       <= enc_any_c;
        multi_hit <= (enc_cnt_c > CW'(1));
        hit_idx   <= enc_idx_c;
        hit_data  <= enc_any_c ? data_mem[enc_idx_c] : '0;
        hit_count <= enc_cnt_c;
      end
    end
  end

endmodule

// File: tb/tb_tcam_search_engine.sv
// Self-checking bench for tcam_search_engine: directed scenarios plus random traffic vs a table model.
module tb_tcam_search_engine;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 5;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic             inv_en;
  logic             flush;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] wr_mask;
  logic             srch_valid;
  logic [WIDTH-1:0] srch_key;
  logic             busy;
  logic             rsp_valid;
  logic             hit;
  logic             multi_hit;
  logic [AW-1:0]    hit_idx;
  logic [WIDTH-1:0] hit_data;
  logic [CW-1:0]    hit_count;

  tcam_search_engine #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .inv_en     (inv_en),
    .flush      (flush),
    .addr       (addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .srch_valid (srch_valid),
    .srch_key   (srch_key),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .hit        (hit),
    .multi_hit  (multi_hit),
    .hit_idx    (hit_idx),
    .hit_data   (hit_data),
    .hit_count  (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          hit;
    bit          multi;
    int          idx;
    int          cnt;
    logic [15:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] m_data  [DEPTH];
  logic [15:0] m_mask  [DEPTH];
  bit          m_valid [DEPTH];
  bit          mbusy = 1'b0;
  int          fptr = 0;
  exp_t        eq [$];
  exp_t        last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: scan the whole table, lowest index wins.
  function automatic exp_t model_search(input logic [15:0] key);
    exp_t r;
    r = '{default: 0};
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && (((key ^ m_data[i]) & ~m_mask[i]) == 16'h0)) begin
        if (r.cnt == 0) r.idx = i;
        r.cnt++;
      end
    end
    r.hit   = (r.cnt > 0);
    r.multi = (r.cnt > 1);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    mbusy = 1'b0;
    fptr  = 0;
    eq.delete();
    last  = '{default: 0};
  endfunction

  // Apply one clock edge of table behaviour to the model.
  function automatic void model_edge(input bit w, input bit iv, input bit fl, input bit sv,
                                     input int a, input logic [15:0] d, input logic [15:0] m,
                                     input logic [15:0] k);
    exp_t r;
    for (int j = 0; j < eq.size(); j++) begin
      if (eq[j].due == cyc) eq[j].data = eq[j].hit ? m_data[eq[j].idx] : 16'h0;
    end
    if (mbusy) begin
      m_valid[fptr] = 1'b0;
      fptr++;
      if (fptr == DEPTH) mbusy = 1'b0;
    end else if (fl) begin
      mbusy = 1'b1;
      fptr  = 0;
    end else begin
      if (sv) begin
        r     = model_search(k);
        r.due = cyc + 1;
        eq.push_back(r);
      end
      if (w) begin
        m_data[a]  = d;
        m_mask[a]  = m;
        m_valid[a] = 1'b1;
      end else if (iv) begin
        m_valid[a] = 1'b0;
      end
    end
  endfunction

  // One cycle: check outputs at the falling edge, drive inputs, then advance the model at the rising edge.
  task automatic step(input bit w, input bit iv, input bit fl, input bit sv, input int a,
                      input logic [15:0] d, input logic [15:0] m, input logic [15:0] k);
    exp_t e;
    @(negedge clk);
    check("busy", 32'(busy), 32'(mbusy));
    if (eq.size() > 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      last = e;
    end else begin
      check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
    check("hit", 32'(hit), 32'(last.hit));
    check("multi_hit", 32'(multi_hit), 32'(last.multi));
    check("hit_idx", 32'(hit_idx), 32'(last.idx));
    check("hit_data", 32'(hit_data), 32'(last.data));
    check("hit_count", 32'(hit_count), 32'(last.cnt));
    wr_en      = w;
    inv_en     = iv;
    flush      = fl;
    srch_valid = sv;
    addr       = 4'(a);
    wr_data    = d;
    wr_mask    = m;
    srch_key   = k;
    @(posedge clk);
    cyc++;
    model_edge(w, iv, fl, sv, a, d, m, k);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic write(input int a, input logic [15:0] d, input logic [15:0] m);
    step(1, 0, 0, 0, a, d, m, 16'h0);
  endtask

  // Search followed by one idle cycle, so the response is on the outputs on return.
  task automatic search(input logic [15:0] k);
    step(0, 0, 0, 1, 0, 16'h0, 16'h0, k);
    idle();
  endtask

  // Directed expectation, sampled just after the edge that registered the response.
  task automatic expect_rsp(input string tag, input bit h, input int idx, input logic [15:0] d,
                            input int cnt, input bit mh);
    #2;
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".hit"}, 32'(hit), 32'(h));
    check({tag, ".hit_idx"}, 32'(hit_idx), 32'(idx));
    check({tag, ".hit_data"}, 32'(hit_data), 32'(d));
    check({tag, ".hit_count"}, 32'(hit_count), 32'(cnt));
    check({tag, ".multi_hit"}, 32'(multi_hit), 32'(mh));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bcnt;
    int          r;
    int          a;
    int          j;
    logic [15:0] key;

    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = 16'h0;
      m_mask[i] = 16'h0;
    end
    model_reset();
    wr_en = 0; inv_en = 0; flush = 0; srch_valid = 0;
    addr = '0; wr_data = '0; wr_mask = '0; srch_key = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Empty table
    search(16'h1234);
    expect_rsp("empty", 0, 0, 16'h0, 0, 0);

    // Single masked entry
    write(3, 16'h12F0, 16'h000F);
    search(16'h12F7);
    expect_rsp("e3_hit", 1, 3, 16'h12F0, 1, 0);
    search(16'h13F7);
    expect_rsp("e3_miss", 0, 0, 16'h0, 0, 0);

    // Overlapping entries, priority and invalidate
    write(5, 16'hAB00, 16'h00FF);
    write(2, 16'hA000, 16'h0FFF);
    search(16'hABCD);
    expect_rsp("multi", 1, 2, 16'hA000, 2, 1);
    step(0, 1, 0, 0, 2, 16'h0, 16'h0, 16'h0);
    search(16'hABCD);
    expect_rsp("after_inv", 1, 5, 16'hAB00, 1, 0);

    // Read during write sees the old table
    step(1, 0, 0, 1, 7, 16'h5555, 16'h0000, 16'h5555);
    idle();
    expect_rsp("rdw_old", 0, 0, 16'h0, 0, 0);
    search(16'h5555);
    expect_rsp("rdw_new", 1, 7, 16'h5555, 1, 0);

    // Fill table, flush, ignored traffic mid-flush
    for (int i = 0; i < DEPTH; i++) write(i, 16'(i) << 4, 16'h0000);
    search(16'h0090);
    expect_rsp("filled", 1, 9, 16'h0090, 1, 0);
    bcnt = 0;
    step(0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
    #2 if (busy) bcnt++;
    for (int s = 1; s < 20; s++) begin
      if (s == 5) step(1, 0, 0, 1, 9, 16'hFFFF, 16'h0000, 16'h0090);
      else        idle();
      #2 if (busy) bcnt++;
    end
    check("busy_cycles", 32'(bcnt), 32'd16);
    search(16'h0090);
    expect_rsp("post_flush", 0, 0, 16'h0, 0, 0);
    search(16'hFFFF);
    expect_rsp("dropped_write", 0, 0, 16'h0, 0, 0);

    // Reset in the 5th cycle of a flush, with a hit still in flight at flush start
    write(1, 16'hBEEF, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0, 16'h0, 16'hBEEF);
    step(0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
    repeat (4) idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.hit", 32'(hit), 32'd0);
    check("rst.multi_hit", 32'(multi_hit), 32'd0);
    check("rst.hit_idx", 32'(hit_idx), 32'd0);
    check("rst.hit_data", 32'(hit_data), 32'd0);
    check("rst.hit_count", 32'(hit_count), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    search(16'hBEEF);
    expect_rsp("post_rst", 0, 0, 16'h0, 0, 0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      r   = $urandom_range(0, 99);
      a   = $urandom_range(0, DEPTH - 1);
      j   = $urandom_range(0, DEPTH - 1);
      key = m_data[j] ^ (16'($urandom) & m_mask[j]);
      if (r % 7 == 0) key = key ^ (16'h1 << $urandom_range(0, 15));
      step(r < 25, r >= 20 && r < 35, r >= 98, $urandom_range(0, 3) != 0, a,
           16'($urandom), 16'($urandom & $urandom & $urandom), key);
    end
    repeat (DEPTH + 4) idle();
    check("pending_responses", 32'(eq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
